// File: rtl/video_timing_detector.sv
// Recovers line/frame geometry from a raw hsync/vsync/de stream,
// reports lock, and regenerates hpos/vpos aligned with de_out.
// Ports: clk, reset (sync, active-high); hsync/vsync/de in;
//   locked, h_total, h_sync_w, h_active, v_total, v_sync_w,
//   v_active, hpos, vpos, de_out out.
module video_timing_detector #(
    parameter logic        HS_POL      = 1'b0,
    parameter logic        VS_POL      = 1'b0,
    parameter logic [3:0]  LOCK_FRAMES = 4'd3,
    parameter logic [23:0] TIMEOUT     = 24'd4000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    output logic        locked,
    output logic [11:0] h_total,
    output logic [11:0] h_sync_w,
    output logic [11:0] h_active,
    output logic [11:0] v_total,
    output logic [11:0] v_sync_w,
    output logic [11:0] v_active,
    output logic [11:0] hpos,
    output logic [11:0] vpos,
    output logic        de_out
);

    localparam logic [11:0] CMAX = 12'hfff;

    function automatic logic [11:0] inc_sat(input logic [11:0] v);
        return (v == CMAX) ? v : v + 12'd1;
    endfunction

    // s1/s2 hold sync levels already normalised to "active = 1"
    logic s1_hs, s1_vs, s1_de;
    logic s2_hs, s2_vs, s2_de;
    logic hs_lead, hs_trail, vs_lead, de_rise, de_fall;

    logic [11:0] h_cnt, hw_cnt, de_cnt;
    logic [11:0] line_len, hs_width, de_run;
    logic [11:0] line_cnt, vw_cnt, act_cnt;
    logic        line_de, frame_sat, frame_valid, vpos_first;
    logic [3:0]  stable_cnt;
    logic [23:0] to_cnt;

    logic        timed_out, new_act, sat_now, same;
    logic [11:0] line_len_nx, hs_width_nx, de_run_nx;

    always_comb begin
        hs_lead   = s1_hs & ~s2_hs;
        hs_trail  = ~s1_hs & s2_hs;
        vs_lead   = s1_vs & ~s2_vs;
        de_rise   = s1_de & ~s2_de;
        de_fall   = ~s1_de & s2_de;
        timed_out = (to_cnt == TIMEOUT);
        // first de cycle of a line marks it as an active line
        new_act   = s1_de & (hs_lead | ~line_de);
        // bypasses let a coincident edge land in the ending frame
        line_len_nx = hs_lead ? inc_sat(h_cnt) : line_len;
        hs_width_nx = hs_trail ? hw_cnt : hs_width;
        de_run_nx   = de_fall ? de_cnt : de_run;
        sat_now = ((h_cnt == CMAX) & ~hs_lead)
                | ((hw_cnt == CMAX) & s1_hs & ~hs_lead)
                | ((de_cnt == CMAX) & s1_de & ~de_rise)
                | ((line_cnt == CMAX) & hs_lead)
                | ((vw_cnt == CMAX) & hs_lead & s1_vs)
                | ((act_cnt == CMAX) & new_act);
        same = ({line_len_nx, hs_width_nx, de_run_nx,
                 line_cnt, vw_cnt, act_cnt} ==
                {h_total, h_sync_w, h_active,
                 v_total, v_sync_w, v_active});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_de       <= 1'b0;
            s2_hs       <= 1'b0;
            s2_vs       <= 1'b0;
            s2_de       <= 1'b0;
            h_cnt       <= '0;
            hw_cnt      <= '0;
            de_cnt      <= '0;
            line_len    <= '0;
            hs_width    <= '0;
            de_run      <= '0;
            line_cnt    <= '0;
            vw_cnt      <= '0;
            act_cnt     <= '0;
            line_de     <= 1'b0;
            frame_sat   <= 1'b0;
            frame_valid <= 1'b0;
            vpos_first  <= 1'b0;
            stable_cnt  <= '0;
            to_cnt      <= '0;
            locked      <= 1'b0;
            h_total     <= '0;
            h_sync_w    <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_sync_w    <= '0;
            v_active    <= '0;
            hpos        <= '0;
            vpos        <= '0;
            de_out      <= 1'b0;
        end else begin
            s1_hs <= (hsync == HS_POL);
            s1_vs <= (vsync == VS_POL);
            s1_de <= de;
            s2_hs <= s1_hs;
            s2_vs <= s1_vs;
            s2_de <= s1_de;

            // pixel position regeneration
            de_out <= s1_de;
            if (s1_de) begin
                hpos <= de_rise ? 12'd0 : inc_sat(hpos);
            end
            if (vs_lead) begin
                vpos_first <= 1'b1;
            end
            if (de_rise) begin
                if (vpos_first || vs_lead) begin
                    vpos       <= 12'd0;
                    vpos_first <= 1'b0;
                end else begin
                    vpos <= inc_sat(vpos);
                end
            end

            // horizontal measurement
            h_cnt    <= hs_lead ? 12'd0 : inc_sat(h_cnt);
            line_len <= line_len_nx;
            if (s1_hs) begin
                hw_cnt <= hs_lead ? 12'd1 : inc_sat(hw_cnt);
            end
            hs_width <= hs_width_nx;
            if (s1_de) begin
                de_cnt <= de_rise ? 12'd1 : inc_sat(de_cnt);
            end
            de_run <= de_run_nx;

            // loss-of-signal watchdog
            if (hs_lead) begin
                to_cnt <= '0;
            end else if (!timed_out) begin
                to_cnt <= to_cnt + 24'd1;
            end

            // vertical measurement; a coincident hs_lead opens the new frame
            if (hs_lead) begin
                line_de <= s1_de;
            end else if (s1_de) begin
                line_de <= 1'b1;
            end
            if (vs_lead) begin
                line_cnt  <= hs_lead ? 12'd1 : 12'd0;
                vw_cnt    <= hs_lead ? 12'd1 : 12'd0;
                act_cnt   <= new_act ? 12'd1 : 12'd0;
                frame_sat <= 1'b0;
            end else begin
                if (hs_lead) begin
                    line_cnt <= inc_sat(line_cnt);
                end
                if (hs_lead && s1_vs) begin
                    vw_cnt <= inc_sat(vw_cnt);
                end
                if (new_act) begin
                    act_cnt <= inc_sat(act_cnt);
                end
                frame_sat <= frame_sat | sat_now;
            end

            // frame commit and lock tracking
            if (timed_out) begin
                locked      <= 1'b0;
                h_total     <= '0;
                h_sync_w    <= '0;
                h_active    <= '0;
                v_total     <= '0;
                v_sync_w    <= '0;
                v_active    <= '0;
                frame_valid <= 1'b0;
                stable_cnt  <= '0;
            end else begin
                locked <= (stable_cnt == LOCK_FRAMES);
                if (vs_lead) begin
                    if (!frame_valid) begin
                        frame_valid <= 1'b1;
                    end else begin
                        h_total  <= line_len_nx;
                        h_sync_w <= hs_width_nx;
                        h_active <= de_run_nx;
                        v_total  <= line_cnt;
                        v_sync_w <= vw_cnt;
                        v_active <= act_cnt;
                        if (same && !(frame_sat || sat_now)) begin
                            if (stable_cnt != LOCK_FRAMES) begin
                                stable_cnt <= stable_cnt + 4'd1;
                            end
                        end else begin
                            stable_cnt <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_detector.sv
// Directed testbench for video_timing_detector.
// Drives synthetic sync streams and checks measurements and lock.
module tb_video_timing_detector;

    logic        clk = 1'b0;
    logic        reset, hsync, vsync, de;
    logic        locked, de_out;
    logic [11:0] h_total, h_sync_w, h_active;
    logic [11:0] v_total, v_sync_w, v_active;
    logic [11:0] hpos, vpos;

    int compared = 0;
    int mismatched = 0;

    int t_ha, t_hfp, t_hs, t_hbp, t_va, t_vfp, t_vs, t_vbp;
    int vs_cnt, since_vs, rise_n, rise_vs, rise_dt;
    int fall_n, fall_vs, fall_dt;
    logic prev_lock, prev_va;
    logic smp_de_out;
    logic [11:0] smp_hpos, smp_vpos;

    always #5 clk = ~clk;

    video_timing_detector #(
        .HS_POL(1'b0),
        .VS_POL(1'b0),
        .LOCK_FRAMES(4'd3),
        .TIMEOUT(24'd6000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .locked(locked),
        .h_total(h_total),
        .h_sync_w(h_sync_w),
        .h_active(h_active),
        .v_total(v_total),
        .v_sync_w(v_sync_w),
        .v_active(v_active),
        .hpos(hpos),
        .vpos(vpos),
        .de_out(de_out)
    );

    // one pixel: sample outputs, then apply pins (negative syncs)
    task automatic drive(input logic ha, input logic va,
                         input logic d);
        @(negedge clk);
        since_vs++;
        smp_de_out = de_out;
        smp_hpos = hpos;
        smp_vpos = vpos;
        if (locked && !prev_lock) begin
            rise_n++;
            rise_vs = vs_cnt;
            rise_dt = since_vs;
        end
        if (!locked && prev_lock) begin
            fall_n++;
            fall_vs = vs_cnt;
            fall_dt = since_vs;
        end
        prev_lock = locked;
        hsync = ~ha;
        vsync = ~va;
        de = d;
        if (va && !prev_va) begin
            vs_cnt++;
            since_vs = 0;
        end
        prev_va = va;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_stats();
        vs_cnt = 0;
        since_vs = 0;
        rise_n = 0;
        rise_vs = 0;
        rise_dt = 0;
        fall_n = 0;
        fall_vs = 0;
        fall_dt = 0;
    endtask

    task automatic set_small();
        t_ha = 16; t_hfp = 2; t_hs = 4; t_hbp = 2;
        t_va = 8;  t_vfp = 1; t_vs = 2; t_vbp = 1;
    endtask

    task automatic set_vga_h();
        t_ha = 640; t_hfp = 16; t_hs = 96; t_hbp = 48;
        t_va = 4;   t_vfp = 1;  t_vs = 2;  t_vbp = 1;
    endtask

    // lines y0..y1-1; line ext_line gets ext extra blank clocks
    task automatic gen_lines(input int y0, input int y1,
                             input int ext_line, input int ext);
        int ht, len;
        ht = t_ha + t_hfp + t_hs + t_hbp;
        for (int y = y0; y < y1; y++) begin
            len = ht + ((y == ext_line) ? ext : 0);
            for (int x = 0; x < len; x++) begin
                drive(x >= t_ha + t_hfp && x < t_ha + t_hfp + t_hs,
                      y >= t_va + t_vfp && y < t_va + t_vfp + t_vs,
                      y < t_va && x < t_ha);
            end
        end
    endtask

    // extending line va+vfp-2 changes the line_len seen at vsync
    task automatic gen_frames(input int n, input int ext);
        int vt;
        vt = t_va + t_vfp + t_vs + t_vbp;
        for (int f = 0; f < n; f++) begin
            gen_lines(0, vt, t_va + t_vfp - 2, ext);
        end
    endtask

    task automatic hard_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
        compared++;
        if (locked !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_locked: got %b expected 0", locked);
        end
        compared++;
        if ({h_total, h_sync_w, h_active, v_total, v_sync_w,
             v_active} !== 72'd0) begin
            mismatched++;
            $display("FAIL reset_meas: got %h expected 0",
                     {h_total, h_sync_w, h_active,
                      v_total, v_sync_w, v_active});
        end
        compared++;
        if ({hpos, vpos, de_out} !== 25'd0) begin
            mismatched++;
            $display("FAIL reset_pos: got %h expected 0",
                     {hpos, vpos, de_out});
        end
        reset = 1'b0;
    endtask

    task automatic test_vga_measure();
        set_vga_h();
        clear_stats();
        gen_frames(3, 0);
        compared++;
        if ({h_total, h_sync_w, h_active, v_total, v_sync_w,
             v_active} !== {12'd800, 12'd96, 12'd640, 12'd8, 12'd2,
                            12'd4}) begin
            mismatched++;
            $display("FAIL vga_meas: got %h expected %h",
                     {h_total, h_sync_w, h_active,
                      v_total, v_sync_w, v_active},
                     {12'd800, 12'd96, 12'd640, 12'd8, 12'd2, 12'd4});
        end
        compared++;
        if (locked !== 1'b0) begin
            mismatched++;
            $display("FAIL vga_early_lock: got %b expected 0", locked);
        end
        gen_frames(2, 0);
        compared++;
        if (locked !== 1'b1) begin
            mismatched++;
            $display("FAIL vga_locked: got %b expected 1", locked);
        end
        compared++;
        if ({rise_n, rise_vs, rise_dt} !== {32'd1, 32'd5, 32'd3}) begin
            mismatched++;
            $display("FAIL vga_lock_time: got n=%0d vs=%0d dt=%0d expected n=1 vs=5 dt=3",
                     rise_n, rise_vs, rise_dt);
        end
    endtask

    task automatic test_hpos_vpos();
        logic d, d1, d2;
        int x1, x2, y1, y2, n;
        hard_reset();
        set_small();
        gen_frames(1, 0);
        d1 = 1'b0; d2 = 1'b0;
        x1 = 0; x2 = 0; y1 = 0; y2 = 0; n = 0;
        for (int y = 0; y < 12; y++) begin
            for (int x = 0; x < 24; x++) begin
                d = (y < 8 && x < 16);
                drive(x >= 18 && x < 22, y >= 9 && y < 11, d);
                if (n >= 2) begin
                    compared++;
                    if (smp_de_out !== d2) begin
                        mismatched++;
                        $display("FAIL de_out_align y=%0d x=%0d: got %b expected %b",
                                 y2, x2, smp_de_out, d2);
                    end
                    if (d2) begin
                        compared++;
                        if (smp_hpos !== 12'(x2)) begin
                            mismatched++;
                            $display("FAIL hpos y=%0d: got %0d expected %0d",
                                     y2, smp_hpos, x2);
                        end
                        compared++;
                        if (smp_vpos !== 12'(y2)) begin
                            mismatched++;
                            $display("FAIL vpos x=%0d: got %0d expected %0d",
                                     x2, smp_vpos, y2);
                        end
                    end
                end
                d2 = d1; x2 = x1; y2 = y1;
                d1 = d;  x1 = x;  y1 = y;
                n++;
            end
        end
        compared++;
        if ({h_total, h_active, v_total, v_active} !==
            {12'd24, 12'd16, 12'd12, 12'd8}) begin
            mismatched++;
            $display("FAIL small_meas: got %h expected %h",
                     {h_total, h_active, v_total, v_active},
                     {12'd24, 12'd16, 12'd12, 12'd8});
        end
    endtask

    task automatic test_lock_perturb();
        hard_reset();
        set_small();
        clear_stats();
        gen_frames(5, 0);
        compared++;
        if (locked !== 1'b1 || rise_vs != 5) begin
            mismatched++;
            $display("FAIL small_lock: got locked=%b vs=%0d expected 1 vs=5",
                     locked, rise_vs);
        end
        clear_stats();
        gen_frames(1, 1);
        compared++;
        if ({fall_n, fall_vs, fall_dt} !== {32'd1, 32'd1, 32'd3}) begin
            mismatched++;
            $display("FAIL perturb_unlock: got n=%0d vs=%0d dt=%0d expected n=1 vs=1 dt=3",
                     fall_n, fall_vs, fall_dt);
        end
        compared++;
        if (h_total !== 12'd25 || locked !== 1'b0) begin
            mismatched++;
            $display("FAIL perturb_meas: got h_total=%0d locked=%b expected 25 0",
                     h_total, locked);
        end
        clear_stats();
        gen_frames(3, 0);
        compared++;
        if (locked !== 1'b0) begin
            mismatched++;
            $display("FAIL relock_early: got %b expected 0", locked);
        end
        gen_frames(1, 0);
        compared++;
        if (locked !== 1'b1 || rise_vs != 4 || h_total !== 12'd24) begin
            mismatched++;
            $display("FAIL relock: got locked=%b vs=%0d h_total=%0d expected 1 4 24",
                     locked, rise_vs, h_total);
        end
    endtask

    task automatic test_timeout();
        idle(6100);
        compared++;
        if (locked !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_locked: got %b expected 0", locked);
        end
        compared++;
        if ({h_total, h_sync_w, h_active, v_total, v_sync_w,
             v_active} !== 72'd0) begin
            mismatched++;
            $display("FAIL timeout_meas: got %h expected 0",
                     {h_total, h_sync_w, h_active,
                      v_total, v_sync_w, v_active});
        end
        clear_stats();
        gen_frames(5, 0);
        compared++;
        if (locked !== 1'b1 || rise_vs != 5) begin
            mismatched++;
            $display("FAIL timeout_relock: got locked=%b vs=%0d expected 1 vs=5",
                     locked, rise_vs);
        end
        compared++;
        if ({h_total, h_sync_w, v_total, v_sync_w} !==
            {12'd24, 12'd4, 12'd12, 12'd2}) begin
            mismatched++;
            $display("FAIL timeout_meas_back: got %h expected %h",
                     {h_total, h_sync_w, v_total, v_sync_w},
                     {12'd24, 12'd4, 12'd12, 12'd2});
        end
    endtask

    task automatic test_reset_mid();
        gen_lines(0, 4, -1, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ({locked, h_total, h_sync_w, h_active, v_total, v_sync_w,
             v_active, hpos, vpos, de_out} !== 98'd0) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {locked, h_total, h_sync_w, h_active, v_total,
                      v_sync_w, v_active, hpos, vpos, de_out});
        end
        reset = 1'b0;
        gen_lines(4, 12, -1, 0);
        compared++;
        if (h_total !== 12'd0 || v_total !== 12'd0 || locked !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_partial: got h=%0d v=%0d locked=%b expected 0 0 0",
                     h_total, v_total, locked);
        end
        gen_frames(1, 0);
        compared++;
        if (h_total !== 12'd24 || v_total !== 12'd12 || locked !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_commit: got h=%0d v=%0d locked=%b expected 24 12 0",
                     h_total, v_total, locked);
        end
    endtask

    task automatic test_long_line();
        hard_reset();
        set_small();
        clear_stats();
        gen_frames(5, 4976);
        compared++;
        if (h_total !== 12'd4095) begin
            mismatched++;
            $display("FAIL long_h_total: got %0d expected 4095", h_total);
        end
        compared++;
        if (rise_n != 0 || locked !== 1'b0) begin
            mismatched++;
            $display("FAIL long_never_lock: got rises=%0d locked=%b expected 0 0",
                     rise_n, locked);
        end
        compared++;
        if (v_total !== 12'd12) begin
            mismatched++;
            $display("FAIL long_v_total: got %0d expected 12", v_total);
        end
    endtask

    initial begin
        reset = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        de = 1'b0;
        prev_lock = 1'b0;
        prev_va = 1'b0;
        clear_stats();
        test_reset();
        test_vga_measure();
        test_hpos_vpos();
        test_lock_perturb();
        test_timeout();
        test_reset_mid();
        test_long_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
